axis_throttled_receiver: RTL and testbench

//  Parametrised AXI-Stream sink/pass-through with deterministic pseudo-random backpressure for adder test harnesses.
//  - Accepts words on s_axis, records the most recent one on `result`, and buffers accepted words in a DEPTH-entry FIFO.
//  - Drains the FIFO on an m_axis master port.
//  - After each accepted beat, inserts a stall of MIN_STALL..MAX_STALL cycles; the stall length comes from an LFSR.
//  - Fully synthesisable; no delays or $urandom.

---
 rtl/axis_rx_pkg.sv | 19 +
 rtl/axis_rx_lfsr16.sv | 32 +++
 rtl/axis_throttled_receiver.sv | 128 ++++++++++++
 tb/tb_axis_throttled_receiver.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_rx_pkg.sv
// Shared constants and helpers for axis_throttled_receiver.
// Build option: AXIS_RX_RAND_STALL_EN selects LFSR-derived stall lengths.
package axis_rx_pkg;

  localparam int unsigned         LFSR_W            = 16;
  // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10)
  localparam logic [LFSR_W-1:0]   LFSR_TAPS         = 16'hB400;
  localparam logic [LFSR_W-1:0]   LFSR_DEFAULT_SEED = 16'hACE1;
  localparam int unsigned         STALL_W           = 8;

  // Ceiling log2; returns 0 for n <= 1
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

endpackage

// File: rtl/axis_rx_lfsr16.sv
// 16-bit Fibonacci LFSR that advances one step per cycle with step high.
// Only compiled when AXIS_RX_RAND_STALL_EN is defined.
`ifdef AXIS_RX_RAND_STALL_EN
module axis_rx_lfsr16
  import axis_rx_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LFSR_W-1:0] seed,
  input  logic              step,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  // Shift left, feeding back the XOR of the tapped bits
  always_comb begin
    lfsr_d = lfsr_q;
    if (step) lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
  end

  // State register, reloads the seed on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= seed;
    else        lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule
`endif

// File: rtl/axis_throttled_receiver.sv
// AXI-Stream sink with a small FIFO pass-through and post-beat stall throttling.
// Build option: AXIS_RX_RAND_STALL_EN -- when defined, each stall length is
// MIN_STALL + (lfsr % (MAX_STALL-MIN_STALL+1)); otherwise it is always MIN_STALL.
module axis_throttled_receiver
  import axis_rx_pkg::*;
#(
  parameter int unsigned       DATA_WIDTH = 16,
  parameter int unsigned       DEPTH      = 4,
  parameter int unsigned       MIN_STALL  = 20,
  parameter int unsigned       MAX_STALL  = 50,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = LFSR_DEFAULT_SEED,
  parameter int unsigned       CNT_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   s_axis_data,
  input  logic                    s_axis_valid,
  output logic                    s_axis_ready,
  output logic [DATA_WIDTH-1:0]   m_axis_data,
  output logic                    m_axis_valid,
  input  logic                    m_axis_ready,
  output logic [DATA_WIDTH-1:0]   result,
  output logic [CNT_WIDTH-1:0]    beat_cnt,
  output logic [clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W  = clog2(DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;
  // Illegal stall/seed settings degrade to no stall instead of an out-of-range count
  localparam bit          CFG_OK = (MIN_STALL <= MAX_STALL) && (MAX_STALL <= 255) &&
                                   (LFSR_SEED != '0);
  localparam int unsigned MIN_EFF = CFG_OK ? MIN_STALL : 0;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic [STALL_W-1:0]    stall_q, stall_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;

  logic                  push_c;
  logic                  pop_c;
  logic [STALL_W-1:0]    stall_len_c;

  // Handshake qualifiers; ready depends only on registers and reset
  assign s_axis_ready = rst_n && (stall_q == '0) && (level_q < LVL_W'(DEPTH));
  assign push_c       = s_axis_valid && s_axis_ready;
  assign m_axis_valid = (level_q != '0);
  assign pop_c        = m_axis_valid && m_axis_ready;
  assign m_axis_data  = mem_q[rd_ptr_q];
  assign result       = result_q;
  assign beat_cnt     = beat_cnt_q;
  assign level        = level_q;

`ifdef AXIS_RX_RAND_STALL_EN
  localparam int unsigned STALL_RANGE = CFG_OK ? (MAX_STALL - MIN_STALL + 1) : 1;

  logic [LFSR_W-1:0] lfsr_c;

  axis_rx_lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .seed  (LFSR_SEED),
    .step  (push_c),
    .q     (lfsr_c)
  );

  // Stall length from the LFSR value before it advances on this accept
  always_comb begin
    stall_len_c = STALL_W'(MIN_EFF) + STALL_W'(lfsr_c % LFSR_W'(STALL_RANGE));
  end
`else
  assign stall_len_c = STALL_W'(MIN_EFF);
`endif

  // Next-state for FIFO bookkeeping, stall counter, result and beat count
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    stall_d    = stall_q;
    result_d   = result_q;
    beat_cnt_d = beat_cnt_q;

    if (push_c) begin
      wr_ptr_d   = wr_ptr_q + PTR_W'(1);
      result_d   = s_axis_data;
      beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
      stall_d    = stall_len_c;
    end else if (stall_q != '0) begin
      stall_d    = stall_q - STALL_W'(1);
    end

    if (pop_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push_c, pop_c})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      stall_q    <= '0;
      result_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      stall_q    <= stall_d;
      result_q   <= result_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= s_axis_data;
  end

endmodule

// File: tb/tb_axis_throttled_receiver.sv
// Directed bench for axis_throttled_receiver; three instances cover the
// zero-stall, fixed-stall and LFSR-stall configurations.
// Build option: AXIS_RX_RAND_STALL_EN changes the expected stall lengths.
module tb_axis_throttled_receiver;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  // Instance a: MIN=MAX=0
  logic [15:0] a_sd, a_md, a_res;
  logic        a_sv, a_sr, a_mv, a_mr;
  logic [31:0] a_cnt;
  logic [2:0]  a_lvl;
  // Instance b: MIN=MAX=3
  logic [15:0] b_sd, b_md, b_res;
  logic        b_sv, b_sr, b_mv, b_mr;
  logic [31:0] b_cnt;
  logic [2:0]  b_lvl;
  // Instance c: MIN=2, MAX=5
  logic [15:0] c_sd, c_md, c_res;
  logic        c_sv, c_sr, c_mv, c_mr;
  logic [31:0] c_cnt;
  logic [2:0]  c_lvl;

  axis_throttled_receiver #(
    .DATA_WIDTH(16), .DEPTH(4), .MIN_STALL(0), .MAX_STALL(0),
    .LFSR_SEED(16'hACE1), .CNT_WIDTH(32)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .s_axis_data(a_sd), .s_axis_valid(a_sv), .s_axis_ready(a_sr),
    .m_axis_data(a_md), .m_axis_valid(a_mv), .m_axis_ready(a_mr),
    .result(a_res), .beat_cnt(a_cnt), .level(a_lvl)
  );

  axis_throttled_receiver #(
    .DATA_WIDTH(16), .DEPTH(4), .MIN_STALL(3), .MAX_STALL(3),
    .LFSR_SEED(16'hACE1), .CNT_WIDTH(32)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .s_axis_data(b_sd), .s_axis_valid(b_sv), .s_axis_ready(b_sr),
    .m_axis_data(b_md), .m_axis_valid(b_mv), .m_axis_ready(b_mr),
    .result(b_res), .beat_cnt(b_cnt), .level(b_lvl)
  );

  axis_throttled_receiver #(
    .DATA_WIDTH(16), .DEPTH(4), .MIN_STALL(2), .MAX_STALL(5),
    .LFSR_SEED(16'hACE1), .CNT_WIDTH(32)
  ) u_dut_c (
    .clk(clk), .rst_n(rst_n),
    .s_axis_data(c_sd), .s_axis_valid(c_sv), .s_axis_ready(c_sr),
    .m_axis_data(c_md), .m_axis_valid(c_mv), .m_axis_ready(c_mr),
    .result(c_res), .beat_cnt(c_cnt), .level(c_lvl)
  );

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Test 4 bookkeeping
  logic [15:0] m_lfsr;
  int unsigned acc, gap, cyc, n_out, exp_len;
  logic [3:0]  seen;
  logic [15:0] drain_exp [3];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_sd = '0; a_sv = 1'b0; a_mr = 1'b0;
    b_sd = '0; b_sv = 1'b0; b_mr = 1'b0;
    c_sd = '0; c_sv = 1'b0; c_mr = 1'b0;
    #1;
    check("rst_ready",  64'(a_sr),  64'd0);
    check("rst_mvalid", 64'(a_mv),  64'd0);
    check("rst_level",  64'(a_lvl), 64'd0);
    check("rst_cnt",    64'(a_cnt), 64'd0);
    check("rst_result", 64'(a_res), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1: zero stall, 8 back-to-back beats with downstream always ready
    a_mr = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      if (i > 1) begin
        check("t1_mdata",  64'(a_md), 64'(i - 1));
        check("t1_mvalid", 64'(a_mv), 64'd1);
      end
      check("t1_ready", 64'(a_sr), 64'd1);
      a_sd = 16'(i);
      a_sv = 1'b1;
      @(negedge clk);
    end
    a_sv = 1'b0;
    check("t1_mdata_last", 64'(a_md),  64'd8);
    check("t1_level_last", 64'(a_lvl), 64'd1);
    check("t1_cnt",        64'(a_cnt), 64'd8);
    check("t1_result",     64'(a_res), 64'd8);
    @(negedge clk);
    check("t1_drain_valid", 64'(a_mv),  64'd0);
    check("t1_drain_level", 64'(a_lvl), 64'd0);

    // Test 3: downstream blocked, 6 beats offered, only 4 fit
    a_mr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("t3_ready", 64'(a_sr), (i < 4) ? 64'd1 : 64'd0);
      a_sd = 16'h0011 + 16'((i < 4) ? i : 4);
      a_sv = 1'b1;
      @(negedge clk);
    end
    check("t3_level_full", 64'(a_lvl), 64'd4);
    check("t3_ready_full", 64'(a_sr),  64'd0);
    check("t3_head",       64'(a_md),  64'h11);
    check("t3_cnt_full",   64'(a_cnt), 64'd12);
    a_mr = 1'b1;
    @(negedge clk);
    a_mr = 1'b0;
    check("t3_level_pop", 64'(a_lvl), 64'd3);
    check("t3_ready_pop", 64'(a_sr),  64'd1);
    check("t3_head_pop",  64'(a_md),  64'h12);
    @(negedge clk);
    check("t3_level_5th",  64'(a_lvl), 64'd4);
    check("t3_result_5th", 64'(a_res), 64'h15);
    check("t3_cnt_5th",    64'(a_cnt), 64'd13);

    // Test 6: full FIFO, push attempt and pop in the same cycle
    a_sd = 16'h0016;
    a_mr = 1'b1;
    check("t6_ready_full", 64'(a_sr), 64'd0);
    @(negedge clk);
    a_sv = 1'b0;
    check("t6_level",  64'(a_lvl), 64'd3);
    check("t6_cnt",    64'(a_cnt), 64'd13);
    check("t6_result", 64'(a_res), 64'h15);
    drain_exp[0] = 16'h0013; drain_exp[1] = 16'h0014; drain_exp[2] = 16'h0015;
    for (int i = 0; i < 3; i++) begin
      check("t6_drain_data",  64'(a_md), 64'(drain_exp[i]));
      check("t6_drain_valid", 64'(a_mv), 64'd1);
      @(negedge clk);
    end
    check("t6_empty_valid", 64'(a_mv),  64'd0);
    check("t6_empty_level", 64'(a_lvl), 64'd0);
    a_mr = 1'b0;

    // Test 2: fixed 3-cycle stall after a single beat
    check("t2_ready_idle", 64'(b_sr), 64'd1);
    b_sd = 16'h1234;
    b_sv = 1'b1;
    @(negedge clk);
    b_sv = 1'b0;
    check("t2_result", 64'(b_res), 64'h1234);
    check("t2_cnt",    64'(b_cnt), 64'd1);
    for (int k = 1; k <= 4; k++) begin
      check("t2_ready_stall", 64'(b_sr), (k == 4) ? 64'd1 : 64'd0);
      if (k < 4) @(negedge clk);
    end

    // Test 5: asynchronous reset mid-stall with two words buffered
    b_sd = 16'h5678;
    b_sv = 1'b1;
    @(negedge clk);
    b_sv = 1'b0;
    check("t5_level_pre", 64'(b_lvl), 64'd2);
    check("t5_ready_pre", 64'(b_sr),  64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_ready_rst",  64'(b_sr),  64'd0);
    check("t5_mvalid_rst", 64'(b_mv),  64'd0);
    check("t5_level_rst",  64'(b_lvl), 64'd0);
    check("t5_cnt_rst",    64'(b_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_level_post",  64'(b_lvl), 64'd0);
    check("t5_result_post", 64'(b_res), 64'd0);
    check("t5_ready_post",  64'(b_sr),  64'd1);
    check("t5_mvalid_post", 64'(b_mv),  64'd0);

    // Test 4: 1000 beats, stall lengths against a reference LFSR
    c_mr    = 1'b1;
    m_lfsr  = 16'hACE1;
    acc     = 0;
    gap     = 0;
    cyc     = 0;
    n_out   = 0;
    exp_len = 0;
    seen    = '0;
    while (acc < 1000 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (c_sr) begin
        if (acc > 0) begin
          check("t4_stall_len", 64'(gap), 64'(exp_len));
          if (gap < 2 || gap > 5) n_out++;
          else seen[gap - 2] = 1'b1;
        end
`ifdef AXIS_RX_RAND_STALL_EN
        exp_len = 2 + 32'(m_lfsr % 16'd4);
        m_lfsr  = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`else
        exp_len = 2;
`endif
        c_sd = 16'(acc + 1);
        c_sv = 1'b1;
        acc++;
        gap  = 0;
      end else begin
        gap++;
      end
    end
    check("t4_beats_done", 64'(acc), 64'd1000);
    @(negedge clk);
    c_sv = 1'b0;
    check("t4_cnt",          64'(c_cnt), 64'd1000);
    check("t4_result",       64'(c_res), 64'd1000);
    check("t4_out_of_range", 64'(n_out), 64'd0);
`ifdef AXIS_RX_RAND_STALL_EN
    check("t4_lengths_seen", 64'(seen), 64'hF);
`else
    check("t4_lengths_seen", 64'(seen), 64'h1);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
